// File: rtl/pose_scheduler.sv
// Sprite raster sequencer: walks the sprite rectangle once per frame, dwells, then steps the pose.
// Optional four-step pose cycle (adds the left pose) is enabled by defining POSE_LEFT_EN.
module pose_scheduler #(
    parameter int X0          = 90,
    parameter int Y0          = 70,
    parameter int SPRITE_W    = 128,
    parameter int SPRITE_H    = 120,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    output logic [13:0] o_rom_addr,
    output logic [8:0]  o_x,
    output logic [7:0]  o_y,
    output logic        o_plot,
    output logic [1:0]  o_pose_sel,
    output logic        o_busy,
    output logic        o_frame_done
);
    localparam logic [8:0]  COL_LAST  = 9'(SPRITE_W - 1);
    localparam logic [7:0]  ROW_LAST  = 8'(SPRITE_H - 1);
    localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_col;
    logic [7:0]  r_row;
    logic [13:0] r_addr;
    logic [27:0] r_hold;
    logic [1:0]  r_pose;
    logic [8:0]  r_x;
    logic [7:0]  r_y;
    logic        r_plot;
    logic [1:0]  r_pose_sel;
    logic        r_busy;
    logic        r_frame_done;

    logic        w_last_px;
    logic        w_hold_end;
    logic [1:0]  w_pose_next;
    logic [8:0]  w_x;
    logic [7:0]  w_y;

    // The pose index is a step counter; the colour-mux code is derived from it.
    function automatic logic [1:0] pose_to_sel(input logic [1:0] step);
`ifdef POSE_LEFT_EN
        logic [1:0] sel;
        if (step[0] == 1'b0) begin
            sel = 2'd0;
        end else if (step[1] == 1'b0) begin
            sel = 2'd1;
        end else begin
            sel = 2'd2;
        end
        return sel;
`else
        return step;
`endif
    endfunction

    assign w_last_px  = (r_state == S_DRAW) && (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_hold_end = (r_state == S_HOLD) && (r_hold == HOLD_LAST);
    assign w_x        = 9'(X0) + r_col;
    assign w_y        = 8'(Y0) + r_row;
`ifdef POSE_LEFT_EN
    assign w_pose_next = r_pose + 2'd1;
`else
    assign w_pose_next = {1'b0, ~r_pose[0]};
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE, stop only at the end of HOLD.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_DRAW;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DRAW: begin
                if (w_last_px) begin
                    w_next = S_HOLD;
                end else begin
                    w_next = S_DRAW;
                end
            end
            S_HOLD: begin
                if (w_hold_end) begin
                    w_next = i_stop ? S_IDLE : S_DRAW;
                end else begin
                    w_next = S_HOLD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Draw-stage counters, dwell counter and pose index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col  <= 9'd0;
            r_row  <= 8'd0;
            r_addr <= 14'd0;
            r_hold <= 28'd0;
            r_pose <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_col  <= 9'd0;
                    r_row  <= 8'd0;
                    r_addr <= 14'd0;
                    r_hold <= 28'd0;
                    r_pose <= 2'd0;
                end
                S_DRAW: begin
                    r_hold <= 28'd0;
                    if (w_last_px) begin
                        r_col  <= 9'd0;
                        r_row  <= 8'd0;
                        r_addr <= 14'd0;
                    end else if (r_col == COL_LAST) begin
                        r_col  <= 9'd0;
                        r_row  <= r_row + 8'd1;
                        r_addr <= r_addr + 14'd1;
                    end else begin
                        r_col  <= r_col + 9'd1;
                        r_addr <= r_addr + 14'd1;
                    end
                end
                S_HOLD: begin
                    r_col  <= 9'd0;
                    r_row  <= 8'd0;
                    r_addr <= 14'd0;
                    if (w_hold_end) begin
                        r_hold <= 28'd0;
                        r_pose <= i_stop ? 2'd0 : w_pose_next;
                    end else begin
                        r_hold <= r_hold + 28'd1;
                    end
                end
                default: begin
                    r_col  <= 9'd0;
                    r_row  <= 8'd0;
                    r_addr <= 14'd0;
                    r_hold <= 28'd0;
                    r_pose <= 2'd0;
                end
            endcase
        end
    end

    // Output stage delayed one cycle to line up with the registered ROM data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x          <= 9'd0;
            r_y          <= 8'd0;
            r_plot       <= 1'b0;
            r_pose_sel   <= 2'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_plot       <= (r_state == S_DRAW);
            r_x          <= (r_state == S_DRAW) ? w_x : 9'd0;
            r_y          <= (r_state == S_DRAW) ? w_y : 8'd0;
            r_pose_sel   <= (r_state == S_DRAW) ? pose_to_sel(r_pose) : 2'd0;
            r_busy       <= (w_next != S_IDLE);
            r_frame_done <= w_last_px;
        end
    end

    assign o_rom_addr   = r_addr;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_plot       = r_plot;
    assign o_pose_sel   = r_pose_sel;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_pose_scheduler.sv
// Scoreboard bench for pose_scheduler with a 4x3 sprite at (10,20) and a 5-cycle dwell.
module tb_pose_scheduler;
    localparam int X0 = 10;
    localparam int Y0 = 20;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HC = 5;
    localparam int NPX = W * H;
    localparam int PERIOD = NPX + HC;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [13:0] rom_addr;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        plot;
    logic [1:0]  pose_sel;
    logic        busy;
    logic        frame_done;

    pose_scheduler #(
        .X0(X0), .Y0(Y0), .SPRITE_W(W), .SPRITE_H(H), .HOLD_CYCLES(HC)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .o_rom_addr(rom_addr), .o_x(x), .o_y(y), .o_plot(plot),
        .o_pose_sel(pose_sel), .o_busy(busy), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int px;
        int py;
        int addr;
        int pose;
        int fd;
    } px_t;

    px_t sb_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  prev_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_pose(input int k);
`ifdef POSE_LEFT_EN
        int tbl[4] = '{0, 1, 0, 2};
        return tbl[k % 4];
`else
        return k % 2;
`endif
    endfunction

    // Expected plots of frame k of a run whose start was sampled at edge ts.
    task automatic push_frame(input int ts, input int k, input int npix);
        for (int i = 0; i < npix; i++) begin
            px_t e;
            e.cyc  = ts + 1 + k * PERIOD + i;
            e.px   = X0 + (i % W);
            e.py   = Y0 + (i / W);
            e.addr = i;
            e.pose = exp_pose(k);
            e.fd   = (npix == NPX && i == NPX - 1) ? 1 : 0;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every plot must match the head of the scoreboard at its expected cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            check_val("missing_plot", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (plot) begin
            if (sb_q.size() == 0 || sb_q[0].cyc > cyc) begin
                check_val("unexpected_plot", cyc, -1);
            end else begin
                px_t e;
                e = sb_q.pop_front();
                check_val("x", int'(x), e.px);
                check_val("y", int'(y), e.py);
                check_val("addr", prev_addr, e.addr);
                check_val("pose_sel", int'(pose_sel), e.pose);
                check_val("frame_done", int'(frame_done), e.fd);
            end
        end else begin
            check_val("fd_without_plot", int'(frame_done), 0);
        end
        prev_addr = int'(rom_addr);
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(output int ts);
        @(negedge clk);
        start = 1'b1;
        ts = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int ts;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_addr", int'(rom_addr), 0);
        check_val("rst_x", int'(x), 0);
        check_val("rst_y", int'(y), 0);
        check_val("rst_plot", int'(plot), 0);
        check_val("rst_pose", int'(pose_sel), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_fd", int'(frame_done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, stop armed early so the run ends after one dwell.
        pulse_start(ts);
        check_val("busy_rise", int'(busy), 1);
        push_frame(ts, 0, NPX);
        wait_to(ts + 5);
        stop = 1'b1;
        wait_to(ts + PERIOD - 1);
        check_val("busy_in_hold", int'(busy), 1);
        wait_to(ts + PERIOD);
        check_val("busy_fall_1", int'(busy), 0);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // Pose cycle with start held high for five frames.
        @(negedge clk);
        start = 1'b1;
        ts = cyc + 1;
        for (int k = 0; k < 5; k++) push_frame(ts, k, NPX);
        wait_to(ts + 4 * PERIOD + 3);
        start = 1'b0;
        stop  = 1'b1;
        wait_to(ts + 5 * PERIOD);
        check_val("busy_fall_5", int'(busy), 0);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // Stop raised mid-frame 2, held through the dwell; no third frame.
        pulse_start(ts);
        push_frame(ts, 0, NPX);
        push_frame(ts, 1, NPX);
        wait_to(ts + PERIOD + 5);
        stop = 1'b1;
        wait_to(ts + 2 * PERIOD);
        check_val("busy_fall_stop", int'(busy), 0);
        repeat (10) @(negedge clk);
        check_val("still_idle", int'(busy), 0);
        stop = 1'b0;
        pulse_start(ts);
        push_frame(ts, 0, NPX);
        wait_to(ts + 3);
        stop = 1'b1;
        wait_to(ts + PERIOD);
        check_val("busy_fall_restart", int'(busy), 0);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // Reset on the sixth draw cycle truncates the frame with no trailing plot.
        pulse_start(ts);
        push_frame(ts, 0, 5);
        wait_to(ts + 5);
        reset = 1'b1;
        wait_to(ts + 6);
        check_val("rst_mid_plot", int'(plot), 0);
        check_val("rst_mid_busy", int'(busy), 0);
        check_val("rst_mid_addr", int'(rom_addr), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_val("rst_mid_idle", int'(busy), 0);

        // Start pulses during DRAW and HOLD must not disturb the sequence.
        pulse_start(ts);
        push_frame(ts, 0, NPX);
        push_frame(ts, 1, NPX);
        wait_to(ts + 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(ts + NPX + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(ts + PERIOD + 3);
        stop = 1'b1;
        wait_to(ts + 2 * PERIOD - 1);
        check_val("busy_dist_hold", int'(busy), 1);
        wait_to(ts + 2 * PERIOD);
        check_val("busy_fall_dist", int'(busy), 0);
        stop = 1'b0;

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
        check_val("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
